alu_sequencer: RTL and testbench

Instruction-level controller for the 4-bit ALU in the 8-bit CPU. It accepts 8-bit instruction bytes over a valid/ready handshake and holds a 4-bit accumulator (ACC) and a 4-bit operand register (B). It issues one ALU operation at a time, waits the ALU's pipeline latency, and writes the result back. It also emits ACC on a result handshake and can halt the core; it sits between the instruction source and the `alu` datapath instance.

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake and datapath bundle between the instruction source, the alu_sequencer and the ALU.
// master = source/ALU side driving instructions, ALU result and result-ready; slave = sequencer.
interface alu_sequencer_if;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready;
    logic       alu_en;
    logic [2:0] alu_opcode;
    logic [3:0] alu_in_1;
    logic [3:0] alu_in_2;
    logic [3:0] alu_out;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ready;
    logic [3:0] acc;
    logic       zero;
    logic       halted;
    logic [7:0] perf_count;

    modport master (
        output instr_valid, instr_data, alu_out, res_ready,
        input  instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2,
               res_valid, res_data, acc, zero, halted, perf_count
    );

    modport slave (
        input  instr_valid, instr_data, alu_out, res_ready,
        output instr_ready, alu_en, alu_opcode, alu_in_1, alu_in_2,
               res_valid, res_data, acc, zero, halted, perf_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 4-bit ALU: one op in flight, ALU_LATENCY cycles from enable to WB.
// Accepts only in IDLE (no input->ready path); OUT stalls on res_ready. Macro ALU_SEQUENCER_PERF_EN adds a retire counter.
module alu_sequencer #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_WAIT, S_WB, S_OUT, S_HALT
    } state_t;

    localparam bit         HAS_WAIT  = (ALU_LATENCY > 1);
    localparam logic [1:0] WAIT_INIT = HAS_WAIT ? 2'(ALU_LATENCY - 2) : 2'd0;

    localparam logic [2:0] OP_LOAD = 3'd6;
    localparam logic [2:0] OP_SYS  = 3'd7;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] b_q, b_d;
    logic       zero_q, zero_d;
    logic [1:0] cnt_q, cnt_d;

    logic [2:0] in_op;
    logic       in_mode;
    logic [3:0] in_imm;
    logic       busy;

    assign in_op   = bus.instr_data[7:5];
    assign in_mode = bus.instr_data[4];
    assign in_imm  = bus.instr_data[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        b_d     = b_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    ir_d = bus.instr_data;
                    if (in_op == OP_LOAD) begin
                        // Loads complete on the accept edge so they can stream one per cycle.
                        if (in_mode) begin
                            b_d = in_imm;
                        end else begin
                            acc_d  = in_imm;
                            zero_d = (in_imm == 4'd0);
                        end
                    end else if (in_op == OP_SYS) begin
                        state_d = in_mode ? S_HALT : S_OUT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (HAS_WAIT) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) state_d = S_WB;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_WB: begin
                acc_d   = bus.alu_out;
                zero_d  = (bus.alu_out == 4'd0);
                state_d = S_IDLE;
            end
            S_OUT: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operands are presented from EXEC through WB; ACC only changes on the WB edge so they stay stable.
    assign busy            = (state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_WB);
    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_en      = (state_q == S_EXEC);
    assign bus.alu_opcode  = busy ? ir_q[7:5] : 3'd0;
    assign bus.alu_in_1    = busy ? acc_q : 4'd0;
    assign bus.alu_in_2    = busy ? (ir_q[4] ? b_q : ir_q[3:0]) : 4'd0;
    assign bus.res_valid   = (state_q == S_OUT);
    assign bus.res_data    = (state_q == S_OUT) ? acc_q : 4'd0;
    assign bus.acc         = acc_q;
    assign bus.zero        = zero_q;
    assign bus.halted      = (state_q == S_HALT);

`ifdef ALU_SEQUENCER_PERF_EN
    logic       retire;
    logic [7:0] perf_q;

    assign retire = ((state_q == S_IDLE) && bus.instr_valid &&
                     ((in_op == OP_LOAD) || ((in_op == OP_SYS) && in_mode))) ||
                    (state_q == S_WB) ||
                    ((state_q == S_OUT) && bus.res_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         perf_q <= '0;
        else if (retire) perf_q <= perf_q + 8'd1;
    end

    assign bus.perf_count = perf_q;
`else
    assign bus.perf_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: three instances at ALU_LATENCY 1, 3 and 4 with pipelined ALU models.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_sequencer_if if1 ();
    alu_sequencer_if if3 ();
    alu_sequencer_if if4 ();

    alu_sequencer #(.ALU_LATENCY(1)) d1 (.clk(clk), .rst(rst), .bus(if1));
    alu_sequencer #(.ALU_LATENCY(3)) d3 (.clk(clk), .rst(rst), .bus(if3));
    alu_sequencer #(.ALU_LATENCY(4)) d4 (.clk(clk), .rst(rst), .bus(if4));

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0:    alu_f = a + b;
            3'd1:    alu_f = a - b;
            3'd2:    alu_f = a & b;
            3'd3:    alu_f = a | b;
            3'd4:    alu_f = a ^ b;
            default: alu_f = ~a;
        endcase
    endfunction

    // ALU models: result appears ALU_LATENCY register stages after the enable cycle; junk otherwise.
    logic [3:0] p1;
    logic [3:0] p3 [3];
    logic [3:0] p4 [4];
    always @(posedge clk) begin
        p1    <= if1.alu_en ? alu_f(if1.alu_opcode, if1.alu_in_1, if1.alu_in_2) : 4'hF;
        p3[0] <= if3.alu_en ? alu_f(if3.alu_opcode, if3.alu_in_1, if3.alu_in_2) : 4'hF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p4[0] <= if4.alu_en ? alu_f(if4.alu_opcode, if4.alu_in_1, if4.alu_in_2) : 4'hF;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign if1.alu_out = p1;
    assign if3.alu_out = p3[2];
    assign if4.alu_out = p4[3];

    function automatic logic [7:0] ins(input logic [2:0] op, input logic mode, input logic [3:0] imm);
        ins = {op, mode, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_ready"},  32'(if1.instr_ready), 1);
        chk({tag, "_alu_en"}, 32'(if1.alu_en), 0);
        chk({tag, "_opc"},    32'(if1.alu_opcode), 0);
        chk({tag, "_in1"},    32'(if1.alu_in_1), 0);
        chk({tag, "_in2"},    32'(if1.alu_in_2), 0);
        chk({tag, "_rvld"},   32'(if1.res_valid), 0);
        chk({tag, "_rdat"},   32'(if1.res_data), 0);
        chk({tag, "_acc"},    32'(if1.acc), 0);
        chk({tag, "_zero"},   32'(if1.zero), 0);
        chk({tag, "_halted"}, 32'(if1.halted), 0);
        chk({tag, "_perf"},   32'(if1.perf_count), 0);
    endtask

    // Issue one instruction to the latency-1 instance and wait (bounded) for ready to return.
    task automatic send1(input logic [7:0] i, output int lat);
        int n;
        if1.instr_valid = 1'b1;
        if1.instr_data  = i;
        tick;
        if1.instr_valid = 1'b0;
        n = 0;
        while (!if1.instr_ready && n < 20) begin
            tick;
            n++;
        end
        if (n >= 20) chk("send1_timeout", 32'(n), 0);
        lat = n;
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    typedef struct {
        logic [7:0] i;
        logic [3:0] acc;
        logic       zero;
    } vec_t;

    vec_t vt [10];

    initial begin
        int lat;
        int n;
        vt[0] = '{ins(3'd6, 1'b0, 4'd3),  4'd3,  1'b0};
        vt[1] = '{ins(3'd6, 1'b1, 4'd5),  4'd3,  1'b0};
        vt[2] = '{ins(3'd0, 1'b0, 4'd4),  4'd7,  1'b0};
        vt[3] = '{ins(3'd1, 1'b1, 4'd0),  4'd2,  1'b0};
        vt[4] = '{ins(3'd1, 1'b0, 4'd2),  4'd0,  1'b1};
        vt[5] = '{ins(3'd6, 1'b1, 4'd0),  4'd0,  1'b1};
        vt[6] = '{ins(3'd6, 1'b0, 4'd15), 4'd15, 1'b0};
        vt[7] = '{ins(3'd0, 1'b0, 4'd1),  4'd0,  1'b1};
        vt[8] = '{ins(3'd1, 1'b0, 4'd1),  4'd15, 1'b0};
        vt[9] = '{ins(3'd2, 1'b0, 4'd9),  4'd9,  1'b0};

        if1.instr_valid = 1'b0; if1.instr_data = '0; if1.res_ready = 1'b0;
        if3.instr_valid = 1'b0; if3.instr_data = '0; if3.res_ready = 1'b0;
        if4.instr_valid = 1'b0; if4.instr_data = '0; if4.res_ready = 1'b0;

        #12;
        chk_reset1("rst0");
        tick;
        rst = 1'b0;
        tick;

        // LOAD ACC 9, LOAD B 8, ADD mode 1 at cycles 0, 1, 2 (latency 1)
        if1.instr_valid = 1'b1;
        if1.instr_data  = ins(3'd6, 1'b0, 4'd9);
        tick;
        chk("ld_acc9", 32'(if1.acc), 9);
        chk("ld_ready", 32'(if1.instr_ready), 1);
        if1.instr_data = ins(3'd6, 1'b1, 4'd8);
        tick;
        chk("ld_b8_ready", 32'(if1.instr_ready), 1);
        if1.instr_data = ins(3'd0, 1'b1, 4'd0);
        tick;
        if1.instr_valid = 1'b0;
        chk("add_exec_en", 32'(if1.alu_en), 1);
        chk("add_exec_in", 32'({if1.alu_opcode, if1.alu_in_1, if1.alu_in_2}), 32'({3'd0, 4'd9, 4'd8}));
        chk("add_exec_rdy", 32'(if1.instr_ready), 0);
        tick;
        chk("add_wb_en", 32'(if1.alu_en), 0);
        chk("add_wb_in", 32'({if1.alu_opcode, if1.alu_in_1, if1.alu_in_2}), 32'({3'd0, 4'd9, 4'd8}));
        chk("add_wb_rdy", 32'(if1.instr_ready), 0);
        tick;
        chk("add_done_rdy", 32'(if1.instr_ready), 1);
        chk("add_acc", 32'(if1.acc), 1);
        chk("add_zero", 32'(if1.zero), 0);
        chk("add_idle_in", 32'({if1.alu_opcode, if1.alu_in_1, if1.alu_in_2}), 0);

        // Table-driven instruction sequence on the latency-1 instance
        for (int k = 0; k < 10; k++) begin
            send1(vt[k].i, lat);
            chk($sformatf("vec%0d_acc", k), 32'(if1.acc), 32'(vt[k].acc));
            chk($sformatf("vec%0d_zero", k), 32'(if1.zero), 32'(vt[k].zero));
        end

        // OUT with res_ready held low for 4 cycles
        send1(ins(3'd6, 1'b0, 4'd7), lat);
        if1.instr_valid = 1'b1;
        if1.instr_data  = ins(3'd7, 1'b0, 4'd0);
        if1.res_ready   = 1'b0;
        tick;
        if1.instr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_hold%0d", k), 32'({if1.res_valid, if1.res_data, if1.instr_ready}), 32'({1'b1, 4'd7, 1'b0}));
            tick;
        end
        if1.res_ready = 1'b1;
        chk("out_hs", 32'({if1.res_valid, if1.res_data}), 32'({1'b1, 4'd7}));
        tick;
        if1.res_ready = 1'b0;
        chk("out_after_vld", 32'(if1.res_valid), 0);
        chk("out_after_rdy", 32'(if1.instr_ready), 1);

        // HALT then a held LOAD that must not be accepted
        if1.instr_valid = 1'b1;
        if1.instr_data  = ins(3'd7, 1'b1, 4'd0);
        tick;
        chk("halt_flag", 32'(if1.halted), 1);
        chk("halt_rdy", 32'(if1.instr_ready), 0);
        if1.instr_data = ins(3'd6, 1'b0, 4'd3);
        tick; tick; tick;
        chk("halt_acc", 32'(if1.acc), 7);
        chk("halt_stay", 32'({if1.halted, if1.instr_ready}), 32'(2'b10));
        if1.instr_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk_reset1("rst_halt");
        tick;
        rst = 1'b0;
        tick;

        // Latency 3: LOAD ACC 5, SUB imm 5
        if3.instr_valid = 1'b1;
        if3.instr_data  = ins(3'd6, 1'b0, 4'd5);
        tick;
        chk("l3_ld", 32'(if3.acc), 5);
        if3.instr_data = ins(3'd1, 1'b0, 4'd5);
        tick;
        if3.instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("l3_ops%0d", k), 32'({if3.alu_opcode, if3.alu_in_1, if3.alu_in_2}), 32'({3'd1, 4'd5, 4'd5}));
            chk($sformatf("l3_en%0d", k), 32'({if3.alu_en, if3.instr_ready}), (k == 1) ? 32'(2'b10) : 32'(2'b00));
            tick;
        end
        chk("l3_rdy", 32'(if3.instr_ready), 1);
        chk("l3_acc", 32'(if3.acc), 0);
        chk("l3_zero", 32'(if3.zero), 1);
        chk("l3_idle_ops", 32'({if3.alu_opcode, if3.alu_in_1, if3.alu_in_2}), 0);

        // Latency 4: reset during WAIT, then a normal ADD
        if4.instr_valid = 1'b1;
        if4.instr_data  = ins(3'd6, 1'b0, 4'd6);
        tick;
        if4.instr_data = ins(3'd0, 1'b0, 4'd3);
        tick;
        if4.instr_valid = 1'b0;
        chk("l4_exec_en", 32'(if4.alu_en), 1);
        tick; tick;
        chk("l4_wait_en", 32'({if4.alu_en, if4.instr_ready}), 0);
        rst = 1'b1;
        #2;
        chk("l4_rst_en", 32'(if4.alu_en), 0);
        chk("l4_rst_acc", 32'(if4.acc), 0);
        chk("l4_rst_rdy", 32'(if4.instr_ready), 1);
        chk("l4_rst_ops", 32'({if4.alu_opcode, if4.alu_in_1, if4.alu_in_2}), 0);
        tick;
        rst = 1'b0;
        tick;
        if4.instr_valid = 1'b1;
        if4.instr_data  = ins(3'd0, 1'b0, 4'd4);
        tick;
        if4.instr_valid = 1'b0;
        n = 1;
        while (!if4.instr_ready && n < 20) begin
            tick;
            n++;
        end
        chk("l4_add_lat", 32'(n), 6);
        chk("l4_add_acc", 32'(if4.acc), 4);
        chk("l4_add_zero", 32'(if4.zero), 0);

        // Retire counter: 260 back-to-back LOADs
        pulse_rst;
        if1.instr_valid = 1'b1;
        for (int k = 0; k < 260; k++) begin
            if1.instr_data = ins(3'd6, 1'b0, 4'(k));
            tick;
        end
        if1.instr_valid = 1'b0;
        chk("perf_ld_acc", 32'(if1.acc), 3);
        chk("perf_ld_rdy", 32'(if1.instr_ready), 1);
`ifdef ALU_SEQUENCER_PERF_EN
        chk("perf_count", 32'(if1.perf_count), 4);
`else
        chk("perf_count", 32'(if1.perf_count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
